// File: rtl/puf_cmd_ctrl.sv
// puf_cmd_ctrl: command sequencer between the UART RX path, the PUF core and
// the UART TX path. Assembles request frames (0xA5, challenge bytes, optional
// XOR checksum), fires one PUF evaluation per valid frame and streams the
// response frame (0x5A, response bytes MSB first, optional XOR checksum).
// Optional feature: define PUF_CMD_CSUM_EN to require and check the request
// checksum and to append a checksum byte to the response.
module puf_cmd_ctrl #(
    parameter int unsigned CHAL_BYTES   = 4,
    parameter int unsigned RESP_BYTES   = 2,
    parameter int unsigned TIMEOUT_CLKS = 17340
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx_dv,
    input  logic [7:0]              rx_byte,
    output logic                    puf_start,
    output logic [8*CHAL_BYTES-1:0] puf_challenge,
    input  logic                    puf_done,
    input  logic [8*RESP_BYTES-1:0] puf_response,
    output logic                    tx_start,
    output logic [7:0]              tx_byte,
    input  logic                    tx_busy,
    output logic                    busy,
    output logic                    frame_err,
    output logic [7:0]              err_count
);

    localparam int unsigned CHAL_W = 8 * CHAL_BYTES;
    localparam int unsigned RESP_W = 8 * RESP_BYTES;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned TMO_W  = 16;
`ifdef PUF_CMD_CSUM_EN
    localparam int unsigned TX_BYTES = RESP_BYTES + 2;
`else
    localparam int unsigned TX_BYTES = RESP_BYTES + 1;
`endif
    localparam logic [7:0] REQ_HDR = 8'hA5;
    localparam logic [7:0] RSP_HDR = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RX_CHAL  = 3'd1,
        ST_RX_CSUM  = 3'd2,
        ST_PUF_REQ  = 3'd3,
        ST_PUF_WAIT = 3'd4,
        ST_TX_SEND  = 3'd5,
        ST_TX_WAIT  = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [CHAL_W-1:0]   chal_q, chal_d;
    logic [RESP_W-1:0]   resp_q, resp_d;
    logic [IDX_W-1:0]    tx_idx_q, tx_idx_d;
    logic [7:0]          tx_byte_q, tx_byte_d;
    logic                puf_start_q, puf_start_d;
    logic                tx_start_q, tx_start_d;
    logic                busy_q, busy_d;
    logic                frame_err_q, frame_err_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic [7:0]          send_byte_c;
`ifdef PUF_CMD_CSUM_EN
    logic [7:0]          xor_q, xor_d;
    logic [7:0]          rsum_q, rsum_d;

    // XOR of all response bytes, used as the response checksum
    function automatic logic [7:0] xor_bytes(input logic [RESP_W-1:0] v);
        logic [7:0] acc;
        acc = 8'h00;
        for (int unsigned i = 0; i < RESP_BYTES; i++) begin
            acc = acc ^ v[8*i +: 8];
        end
        return acc;
    endfunction
`endif

    // Byte to transmit at the current position of the response frame
    always_comb begin
        send_byte_c = resp_q[RESP_W-1 -: 8];
        if (tx_idx_q == '0) begin
            send_byte_c = RSP_HDR;
        end
`ifdef PUF_CMD_CSUM_EN
        else if (tx_idx_q == IDX_W'(RESP_BYTES + 1)) begin
            send_byte_c = rsum_q;
        end
`endif
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        chal_d      = chal_q;
        resp_d      = resp_q;
        tx_idx_d    = tx_idx_q;
        tx_byte_d   = tx_byte_q;
        puf_start_d = 1'b0;
        tx_start_d  = 1'b0;
        frame_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;
`ifdef PUF_CMD_CSUM_EN
        xor_d       = xor_q;
        rsum_d      = rsum_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (rx_dv && (rx_byte == REQ_HDR)) begin
                    state_d = ST_RX_CHAL;
                    idx_d   = '0;
                    tmo_d   = '0;
`ifdef PUF_CMD_CSUM_EN
                    xor_d   = 8'h00;
`endif
                end
            end

            ST_RX_CHAL: begin
                if (rx_dv) begin
                    chal_d = CHAL_W'({chal_q, rx_byte});
                    tmo_d  = '0;
                    idx_d  = idx_q + IDX_W'(1);
`ifdef PUF_CMD_CSUM_EN
                    xor_d  = xor_q ^ rx_byte;
`endif
                    if (idx_q == IDX_W'(CHAL_BYTES - 1)) begin
`ifdef PUF_CMD_CSUM_EN
                        state_d = ST_RX_CSUM;
`else
                        state_d     = ST_PUF_REQ;
                        puf_start_d = 1'b1;
`endif
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT_CLKS - 1)) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

`ifdef PUF_CMD_CSUM_EN
            ST_RX_CSUM: begin
                if (rx_dv) begin
                    tmo_d = '0;
                    if (rx_byte == xor_q) begin
                        state_d     = ST_PUF_REQ;
                        puf_start_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT_CLKS - 1)) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
`endif

            ST_PUF_REQ: begin
                state_d = ST_PUF_WAIT;
            end

            ST_PUF_WAIT: begin
                if (puf_done) begin
                    resp_d   = puf_response;
                    tx_idx_d = '0;
                    state_d  = ST_TX_SEND;
`ifdef PUF_CMD_CSUM_EN
                    rsum_d   = xor_bytes(puf_response);
`endif
                    // Header goes out immediately when the transmitter is free
                    if (!tx_busy) begin
                        tx_byte_d  = RSP_HDR;
                        tx_start_d = 1'b1;
                        tx_idx_d   = IDX_W'(1);
                        state_d    = ST_TX_WAIT;
                    end
                end
            end

            ST_TX_SEND: begin
                if (!tx_busy) begin
                    tx_byte_d  = send_byte_c;
                    tx_start_d = 1'b1;
                    tx_idx_d   = tx_idx_q + IDX_W'(1);
                    state_d    = ST_TX_WAIT;
                    if (tx_idx_q != '0) begin
                        resp_d = resp_q << 8;
                    end
                end
            end

            ST_TX_WAIT: begin
                // tx_start_q marks the first wait cycle, where tx_busy may lag
                if (!tx_start_q && !tx_busy) begin
                    if (tx_idx_q == IDX_W'(TX_BYTES)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_TX_SEND;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (frame_err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            tmo_q       <= '0;
            chal_q      <= '0;
            resp_q      <= '0;
            tx_idx_q    <= '0;
            tx_byte_q   <= 8'h00;
            puf_start_q <= 1'b0;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= 8'h00;
`ifdef PUF_CMD_CSUM_EN
            xor_q       <= 8'h00;
            rsum_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            chal_q      <= chal_d;
            resp_q      <= resp_d;
            tx_idx_q    <= tx_idx_d;
            tx_byte_q   <= tx_byte_d;
            puf_start_q <= puf_start_d;
            tx_start_q  <= tx_start_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
`ifdef PUF_CMD_CSUM_EN
            xor_q       <= xor_d;
            rsum_q      <= rsum_d;
`endif
        end
    end

    assign puf_start     = puf_start_q;
    assign puf_challenge = chal_q;
    assign tx_start      = tx_start_q;
    assign tx_byte       = tx_byte_q;
    assign busy          = busy_q;
    assign frame_err     = frame_err_q;
    assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_puf_cmd_ctrl.sv
// Testbench for puf_cmd_ctrl: scoreboard of expected challenges and TX bytes,
// one task per scenario, simple transmitter model driving tx_busy.
module tb_puf_cmd_ctrl;

    localparam int unsigned CB  = 4;
    localparam int unsigned RB  = 2;
    localparam int unsigned TMO = 300;
`ifdef PUF_CMD_CSUM_EN
    localparam int TXN = 4;
`else
    localparam int TXN = 3;
`endif

    logic              clk;
    logic              rst;
    logic              rx_dv;
    logic [7:0]        rx_byte;
    logic              puf_start;
    logic [8*CB-1:0]   puf_challenge;
    logic              puf_done;
    logic [8*RB-1:0]   puf_response;
    logic              tx_start;
    logic [7:0]        tx_byte;
    logic              tx_busy;
    logic              busy;
    logic              frame_err;
    logic [7:0]        err_count;

    logic              model_busy;
    logic              hold_busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_tx = -100;
    int tx_cnt = 0;
    int puf_cnt = 0;
    int fe_cnt = 0;

    logic [7:0]        exp_q[$];
    logic [8*CB-1:0]   exp_chal_q[$];

    assign tx_busy = model_busy | hold_busy;

    puf_cmd_ctrl #(
        .CHAL_BYTES  (CB),
        .RESP_BYTES  (RB),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_dv        (rx_dv),
        .rx_byte      (rx_byte),
        .puf_start    (puf_start),
        .puf_challenge(puf_challenge),
        .puf_done     (puf_done),
        .puf_response (puf_response),
        .tx_start     (tx_start),
        .tx_byte      (tx_byte),
        .tx_busy      (tx_busy),
        .busy         (busy),
        .frame_err    (frame_err),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model: busy for a few cycles after each tx_start
    initial begin
        model_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                model_busy = 1'b1;
                repeat (4) @(negedge clk);
                model_busy = 1'b0;
            end
        end
    end

    // Output monitor: pops scoreboard entries when the DUT produces output
    initial begin
        logic [7:0]      eb;
        logic [8*CB-1:0] ec;
        forever begin
            @(negedge clk);
            cyc++;
            if (frame_err === 1'b1) fe_cnt++;
            if (puf_start === 1'b1) begin
                puf_cnt++;
                n_cmp++;
                if (exp_chal_q.size() == 0) begin
                    n_err++;
                    $display("FAIL puf_start_unexpected: got puf_start=1 challenge=%h, required no pulse", puf_challenge);
                end else begin
                    ec = exp_chal_q.pop_front();
                    if (puf_challenge !== ec) begin
                        n_err++;
                        $display("FAIL puf_challenge: got %h, required %h", puf_challenge, ec);
                    end
                end
            end
            if (tx_start === 1'b1) begin
                tx_cnt++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL tx_start_unexpected: got tx_byte=%h, required no tx_start", tx_byte);
                end else begin
                    eb = exp_q.pop_front();
                    if (tx_byte !== eb) begin
                        n_err++;
                        $display("FAIL tx_byte: got %h, required %h", tx_byte, eb);
                    end
                end
                n_cmp++;
                if (cyc - last_tx < 3) begin
                    n_err++;
                    $display("FAIL tx_spacing: got %0d cycles, required >= 3", cyc - last_tx);
                end
                last_tx = cyc;
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst      = 1'b1;
        rx_dv    = 1'b0;
        puf_done = 1'b0;
        hold_busy = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_chal_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv   = 1'b0;
    endtask

    // Sends a request frame; csum_flip corrupts the checksum byte
    task automatic send_frame(input logic [31:0] chal, input logic [7:0] csum_flip,
                              input bit expect_start);
        logic [7:0] b;
        logic [7:0] cs;
        cs = 8'h00;
        if (expect_start) exp_chal_q.push_back(chal);
        send_byte(8'hA5);
        for (int i = 0; i < 4; i++) begin
            b  = chal[31-8*i -: 8];
            cs = cs ^ b;
            send_byte(b);
        end
`ifdef PUF_CMD_CSUM_EN
        send_byte(cs ^ csum_flip);
`endif
        n_cmp++;
        if (puf_start !== expect_start) begin
            n_err++;
            $display("FAIL puf_start_timing: got %b, required %b", puf_start, expect_start);
        end
        if (expect_start) begin
            @(negedge clk);
            n_cmp++;
            if (puf_start !== 1'b0) begin
                n_err++;
                $display("FAIL puf_start_width: got %b, required 0", puf_start);
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while (busy !== 1'b0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_wait: got busy=%b after %0d cycles, required 0", busy, c);
        end
    endtask

    // Returns a PUF response and checks the resulting response frame
    task automatic do_response(input logic [15:0] r);
        bit free;
        exp_q.push_back(8'h5A);
        exp_q.push_back(r[15:8]);
        exp_q.push_back(r[7:0]);
`ifdef PUF_CMD_CSUM_EN
        exp_q.push_back(r[15:8] ^ r[7:0]);
`endif
        free         = (tx_busy === 1'b0);
        puf_response = r;
        puf_done     = 1'b1;
        @(negedge clk);
        puf_done     = 1'b0;
        if (free) begin
            n_cmp++;
            if (tx_start !== 1'b1) begin
                n_err++;
                $display("FAIL first_tx_latency: got tx_start=%b, required 1", tx_start);
            end
        end
        wait_idle(2000);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL tx_missing: got %0d bytes outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp += 7;
        if (puf_start !== 1'b0) begin n_err++; $display("FAIL rst_puf_start: got %b, required 0", puf_start); end
        if (tx_start !== 1'b0) begin n_err++; $display("FAIL rst_tx_start: got %b, required 0", tx_start); end
        if (tx_byte !== 8'h00) begin n_err++; $display("FAIL rst_tx_byte: got %h, required 00", tx_byte); end
        if (puf_challenge !== '0) begin n_err++; $display("FAIL rst_challenge: got %h, required 0", puf_challenge); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b, required 0", busy); end
        if (frame_err !== 1'b0) begin n_err++; $display("FAIL rst_frame_err: got %b, required 0", frame_err); end
        if (err_count !== 8'h00) begin n_err++; $display("FAIL rst_err_count: got %h, required 00", err_count); end
    endtask

    task automatic test_valid();
        int base_tx;
        base_tx = tx_cnt;
        send_frame(32'h12345678, 8'h00, 1'b1);
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL valid_busy: got %b, required 1", busy); end
        do_response(16'hBEEF);
        n_cmp++;
        if (tx_cnt - base_tx != TXN) begin
            n_err++;
            $display("FAIL valid_tx_count: got %0d, required %0d", tx_cnt - base_tx, TXN);
        end
        n_cmp++;
        if (err_count !== 8'h00) begin n_err++; $display("FAIL valid_err_count: got %h, required 00", err_count); end
    endtask

    task automatic test_bad_csum();
        int base_puf;
        do_reset();
        base_puf = puf_cnt;
`ifdef PUF_CMD_CSUM_EN
        send_frame(32'h12345678, 8'h01, 1'b0);
        n_cmp += 2;
        if (frame_err !== 1'b1) begin n_err++; $display("FAIL csum_frame_err: got %b, required 1", frame_err); end
        if (err_count !== 8'h01) begin n_err++; $display("FAIL csum_err_count: got %h, required 01", err_count); end
        @(negedge clk);
        n_cmp += 2;
        if (frame_err !== 1'b0) begin n_err++; $display("FAIL csum_err_width: got %b, required 0", frame_err); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL csum_busy: got %b, required 0", busy); end
`else
        send_byte(8'h09);
        n_cmp += 2;
        if (frame_err !== 1'b0) begin n_err++; $display("FAIL stray_frame_err: got %b, required 0", frame_err); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL stray_busy: got %b, required 0", busy); end
`endif
        n_cmp++;
        if (puf_cnt != base_puf) begin
            n_err++;
            $display("FAIL csum_no_start: got %0d pulses, required 0", puf_cnt - base_puf);
        end
    endtask

    task automatic test_timeout();
        int c;
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h12);
        c = 0;
        while (frame_err !== 1'b1 && c < int'(TMO) + 20) begin
            @(negedge clk);
            c++;
        end
        n_cmp++;
        if (c < int'(TMO) - 1 || c > int'(TMO) + 1) begin
            n_err++;
            $display("FAIL timeout_latency: got %0d cycles, required %0d..%0d", c, TMO - 1, TMO + 1);
        end
        n_cmp++;
        if (err_count !== 8'h01) begin n_err++; $display("FAIL timeout_err_count: got %h, required 01", err_count); end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL timeout_busy: got %b, required 0", busy); end
        send_frame(32'h0F1E2D3C, 8'h00, 1'b1);
        do_response(16'h1234);
        n_cmp++;
        if (err_count !== 8'h01) begin n_err++; $display("FAIL timeout_recovery: got %h, required 01", err_count); end
    endtask

    task automatic test_garbage();
        int base_fe;
        int base_puf;
        do_reset();
        base_fe  = fe_cnt;
        base_puf = puf_cnt;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h3C);
        send_frame(32'hCAFEF00D, 8'h00, 1'b1);
        do_response(16'h0102);
        n_cmp += 3;
        if (fe_cnt != base_fe) begin n_err++; $display("FAIL garbage_frame_err: got %0d pulses, required 0", fe_cnt - base_fe); end
        if (puf_cnt - base_puf != 1) begin n_err++; $display("FAIL garbage_puf_start: got %0d pulses, required 1", puf_cnt - base_puf); end
        if (err_count !== 8'h00) begin n_err++; $display("FAIL garbage_err_count: got %h, required 00", err_count); end
    endtask

    task automatic test_busy_hold();
        int base_tx;
        int base_puf;
        logic [7:0] extra[6];
        extra = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        send_frame(32'hA1B2C3D4, 8'h00, 1'b1);
        base_puf = puf_cnt;
        hold_busy = 1'b1;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'hDE);
`ifdef PUF_CMD_CSUM_EN
        exp_q.push_back(8'hC0 ^ 8'hDE);
`endif
        puf_response = 16'hC0DE;
        puf_done     = 1'b1;
        @(negedge clk);
        puf_done     = 1'b0;
        base_tx = tx_cnt;
        for (int i = 0; i < 500; i++) begin
            if (i >= 10 && i < 16) send_byte(extra[i-10]);
            else @(negedge clk);
        end
        n_cmp++;
        if (tx_cnt != base_tx) begin n_err++; $display("FAIL busy_hold_tx: got %0d tx_start, required 0", tx_cnt - base_tx); end
        hold_busy = 1'b0;
        wait_idle(2000);
        repeat (5) @(negedge clk);
        n_cmp += 4;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL busy_hold_bytes: got %0d outstanding, required 0", exp_q.size()); end
        if (tx_cnt - base_tx != TXN) begin n_err++; $display("FAIL busy_hold_count: got %0d, required %0d", tx_cnt - base_tx, TXN); end
        if (puf_cnt != base_puf) begin n_err++; $display("FAIL busy_hold_drop: got %0d extra puf_start, required 0", puf_cnt - base_puf); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL busy_hold_idle: got %b, required 0", busy); end
    endtask

    task automatic test_reset_mid();
        int base_tx;
        int base_puf;
        send_frame(32'h0BADCAFE, 8'h00, 1'b1);
        base_tx  = tx_cnt;
        base_puf = puf_cnt;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp += 4;
        if (puf_challenge !== '0) begin n_err++; $display("FAIL mid_rst_challenge: got %h, required 0", puf_challenge); end
        if (tx_byte !== 8'h00) begin n_err++; $display("FAIL mid_rst_tx_byte: got %h, required 00", tx_byte); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b, required 0", busy); end
        if (err_count !== 8'h00) begin n_err++; $display("FAIL mid_rst_err_count: got %h, required 00", err_count); end
        rst = 1'b0;
        @(negedge clk);
        puf_response = 16'h5555;
        puf_done     = 1'b1;
        @(negedge clk);
        puf_done     = 1'b0;
        repeat (50) @(negedge clk);
        n_cmp += 5;
        if (tx_cnt != base_tx) begin n_err++; $display("FAIL mid_rst_tx: got %0d tx_start, required 0", tx_cnt - base_tx); end
        if (puf_cnt != base_puf) begin n_err++; $display("FAIL mid_rst_puf: got %0d puf_start, required 0", puf_cnt - base_puf); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_idle: got %b, required 0", busy); end
        if (tx_start !== 1'b0) begin n_err++; $display("FAIL mid_rst_tx_start: got %b, required 0", tx_start); end
        if (frame_err !== 1'b0) begin n_err++; $display("FAIL mid_rst_frame_err: got %b, required 0", frame_err); end
    endtask

    initial begin
        rst          = 1'b1;
        rx_dv        = 1'b0;
        rx_byte      = 8'h00;
        puf_done     = 1'b0;
        puf_response = '0;
        hold_busy    = 1'b0;
        test_reset();
        test_valid();
        test_bad_csum();
        test_timeout();
        test_garbage();
        test_busy_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
